// File: rtl/ram_block_mover_pkg.sv
// Shared definitions for the RAM block mover.
// Holds the controller state encoding and the default address/data widths.
package ram_block_mover_pkg;

  localparam int AW_DEFAULT = 16;
  localparam int DW_DEFAULT = 24;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    FILL = 3'd4,
    FIN  = 3'd5
  } state_t;

endpackage

// File: rtl/ram_addr_gen.sv
// Address/count generator for the RAM block mover.
// Holds the source pointer, destination pointer and remaining word count.
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   load               take src_in/dst_in/len_in as the new command
//   step_src           advance the source pointer by one (wraps mod 2^AW)
//   step_dst           advance the destination pointer and decrement the count
//   src_in/dst_in/len_in  command values captured on load
//   src_next/dst_next  pointer values that will be current next cycle
//   remaining          current remaining word count
module ram_addr_gen #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step_src,
  input  logic          step_dst,
  input  logic [AW-1:0] src_in,
  input  logic [AW-1:0] dst_in,
  input  logic [AW-1:0] len_in,
  output logic [AW-1:0] src_next,
  output logic [AW-1:0] dst_next,
  output logic [AW-1:0] remaining
);

  logic [AW-1:0] src_reg;
  logic [AW-1:0] dst_reg;
  logic [AW-1:0] cnt_reg;
  logic [AW-1:0] cnt_next;

  // Next values are exported so the owner can register its RAM address
  // outputs one cycle ahead and still present the pointer of the cycle.
  always_comb begin
    src_next = src_reg;
    dst_next = dst_reg;
    cnt_next = cnt_reg;
    if (load) begin
      src_next = src_in;
      dst_next = dst_in;
      cnt_next = len_in;
    end else begin
      if (step_src) begin
        src_next = src_reg + 1'b1;
      end
      if (step_dst) begin
        dst_next = dst_reg + 1'b1;
        cnt_next = cnt_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_reg <= '0;
      dst_reg <= '0;
      cnt_reg <= '0;
    end else begin
      src_reg <= src_next;
      dst_reg <= dst_next;
      cnt_reg <= cnt_next;
    end
  end

  assign remaining = cnt_reg;

endmodule

// File: rtl/ram_block_mover.sv
// RAM block mover: copies LEN words from SRC to DST (3 cycles/word) or fills
// LEN words at DST with PATTERN (1 cycle/word) over a single-port RAM with
// one-cycle read latency.
// Ports:
//   CK, RST_N          clock and synchronous active-low reset
//   START, MODE        command strobe (IDLE only); 0 = copy, 1 = fill
//   SRC, DST, LEN      source base, destination base, word count (0 = no-op)
//   PATTERN            fill value
//   BUSY, DONE         busy status; one-cycle completion pulse
//   RAM_A/WE/OE/D      registered RAM address, write enable, output enable, data
//   RAM_Q              RAM read data, valid the cycle after an OE address
module ram_block_mover
  import ram_block_mover_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          CK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          MODE,
  input  logic [AW-1:0] SRC,
  input  logic [AW-1:0] DST,
  input  logic [AW-1:0] LEN,
  input  logic [DW-1:0] PATTERN,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] RAM_A,
  output logic          RAM_WE,
  output logic          RAM_OE,
  output logic [DW-1:0] RAM_D,
  input  logic [DW-1:0] RAM_Q
);

  state_t        state_reg, state_next;
  logic          mode_reg, mode_next;
  logic [DW-1:0] pattern_reg, pattern_next;
  logic [DW-1:0] buffer_reg, buffer_next;

  logic          load, step_src, step_dst;
  logic [AW-1:0] src_next, dst_next, remaining;

  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [AW-1:0] ram_a_reg, ram_a_next;
  logic          ram_we_reg, ram_we_next;
  logic          ram_oe_reg, ram_oe_next;
  logic [DW-1:0] ram_d_reg, ram_d_next;

  ram_addr_gen #(.AW(AW)) u_addr_gen (
    .clk       (CK),
    .rst_n     (RST_N),
    .load      (load),
    .step_src  (step_src),
    .step_dst  (step_dst),
    .src_in    (SRC),
    .dst_in    (DST),
    .len_in    (LEN),
    .src_next  (src_next),
    .dst_next  (dst_next),
    .remaining (remaining)
  );

  // Next-state and datapath control.
  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    pattern_next = pattern_reg;
    buffer_next  = buffer_reg;
    load         = 1'b0;
    step_src     = 1'b0;
    step_dst     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (START) begin
          load         = 1'b1;
          mode_next    = MODE;
          pattern_next = PATTERN;
          if (LEN == '0)  state_next = FIN;
          else if (MODE)  state_next = FILL;
          else            state_next = RD;
        end
      end
      RD:  state_next = CAP;
      CAP: begin
        buffer_next = RAM_Q;
        state_next  = WR;
      end
      WR: begin
        step_src   = !mode_reg;
        step_dst   = 1'b1;
        // Count is still pre-decrement here, so 1 means this was the last word.
        state_next = (remaining == AW'(1)) ? FIN : RD;
      end
      FILL: begin
        step_dst   = 1'b1;
        state_next = (remaining == AW'(1)) ? FIN : FILL;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM-side outputs are registered, so they are derived from the state and
  // pointers of the coming cycle.
  always_comb begin
    ram_a_next  = '0;
    ram_we_next = 1'b0;
    ram_oe_next = 1'b0;
    ram_d_next  = '0;
    busy_next   = (state_next != IDLE);
    done_next   = (state_next == FIN);
    case (state_next)
      RD, CAP: begin
        ram_a_next  = src_next;
        ram_oe_next = 1'b1;
      end
      WR: begin
        ram_a_next  = dst_next;
        ram_we_next = 1'b1;
        ram_d_next  = buffer_next;
      end
      FILL: begin
        ram_a_next  = dst_next;
        ram_we_next = 1'b1;
        ram_d_next  = pattern_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      state_reg   <= IDLE;
      mode_reg    <= 1'b0;
      pattern_reg <= '0;
      buffer_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      ram_a_reg   <= '0;
      ram_we_reg  <= 1'b0;
      ram_oe_reg  <= 1'b0;
      ram_d_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      pattern_reg <= pattern_next;
      buffer_reg  <= buffer_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      ram_a_reg   <= ram_a_next;
      ram_we_reg  <= ram_we_next;
      ram_oe_reg  <= ram_oe_next;
      ram_d_reg   <= ram_d_next;
    end
  end

  assign BUSY   = busy_reg;
  assign DONE   = done_reg;
  assign RAM_A  = ram_a_reg;
  assign RAM_WE = ram_we_reg;
  assign RAM_OE = ram_oe_reg;
  assign RAM_D  = ram_d_reg;

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: behavioural RAM (address latched on CK, read
// data one cycle later), bus activity monitors and directed scenarios.
module tb_ram_block_mover;

  logic        CK = 1'b0;
  logic        RST_N;
  logic        START;
  logic        MODE;
  logic [15:0] SRC, DST, LEN;
  logic [23:0] PATTERN;
  logic        BUSY, DONE;
  logic [15:0] RAM_A;
  logic        RAM_WE, RAM_OE;
  logic [23:0] RAM_D;
  logic [23:0] RAM_Q;

  logic [23:0] mem [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_a  = '0;
  logic [23:0] pre_d  = '0;

  int we_count   = 0;
  int oe_count   = 0;
  int done_count = 0;
  int busy_count = 0;
  int both_count = 0;

  int checks   = 0;
  int failures = 0;

  always #5 CK = ~CK;

  ram_block_mover dut (
    .CK(CK), .RST_N(RST_N), .START(START), .MODE(MODE),
    .SRC(SRC), .DST(DST), .LEN(LEN), .PATTERN(PATTERN),
    .BUSY(BUSY), .DONE(DONE), .RAM_A(RAM_A), .RAM_WE(RAM_WE),
    .RAM_OE(RAM_OE), .RAM_D(RAM_D), .RAM_Q(RAM_Q)
  );

  // Behavioural RAM plus activity counters.
  always @(posedge CK) begin
    if (pre_we)      mem[pre_a] <= pre_d;
    else if (RAM_WE) mem[RAM_A] <= RAM_D;
    if (RAM_OE) RAM_Q <= mem[RAM_A];
    if (RAM_WE) we_count <= we_count + 1;
    if (RAM_OE) oe_count <= oe_count + 1;
    if (DONE)   done_count <= done_count + 1;
    if (BUSY)   busy_count <= busy_count + 1;
    if (RAM_WE && RAM_OE) both_count <= both_count + 1;
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [23:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    tick();
    pre_we = 1'b0;
  endtask

  // Returns in the first busy cycle (one edge after START is sampled).
  task automatic do_start(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic [23:0] p);
    MODE = m; SRC = s; DST = d; LEN = l; PATTERN = p; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Cycles from now until DONE is seen; 100 means it never came.
  task automatic wait_done(output int n);
    n = 0;
    while (!DONE && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b0; MODE = 1'b0;
    SRC = '0; DST = '0; LEN = '0; PATTERN = '0;
    repeat (3) tick();
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: BUSY=%b DONE=%b required 0 0", BUSY, DONE);
    end
    checks++;
    if (RAM_WE !== 1'b0 || RAM_OE !== 1'b0) begin
      failures++;
      $display("FAIL reset_enables: WE=%b OE=%b required 0 0", RAM_WE, RAM_OE);
    end
    checks++;
    if (RAM_A !== 16'h0 || RAM_D !== 24'h0) begin
      failures++;
      $display("FAIL reset_bus: A=%h D=%h required 0000 000000", RAM_A, RAM_D);
    end
    RST_N = 1'b1;
    tick();
    $display("reset: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_copy();
    int n, we0, done0;
    for (int i = 0; i < 4; i++) begin
      preload(16'h0010 + 16'(i), 24'hA00001 + 24'(i));
      preload(16'h0100 + 16'(i), 24'h000000);
    end
    we0 = we_count; done0 = done_count;
    do_start(1'b0, 16'h0010, 16'h0100, 16'd4, 24'h0);
    checks++;
    if (BUSY !== 1'b1 || RAM_OE !== 1'b1 || RAM_WE !== 1'b0 || RAM_A !== 16'h0010) begin
      failures++;
      $display("FAIL copy_first_read: BUSY=%b OE=%b WE=%b A=%h required 1 1 0 0010",
               BUSY, RAM_OE, RAM_WE, RAM_A);
    end
    wait_done(n);
    checks++;
    if (n != 12) begin
      failures++;
      $display("FAIL copy_latency: DONE after %0d cycles required 12", n);
    end
    tick();
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL copy_end: BUSY=%b DONE=%b required 0 0", BUSY, DONE);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h0100 + 16'(i)] !== 24'hA00001 + 24'(i)) begin
        failures++;
        $display("FAIL copy_data[%0d]: got %h required %h", i,
                 mem[16'h0100 + 16'(i)], 24'hA00001 + 24'(i));
      end
    end
    checks++;
    if (we_count - we0 != 4 || done_count - done0 != 1) begin
      failures++;
      $display("FAIL copy_counts: writes=%0d dones=%0d required 4 1",
               we_count - we0, done_count - done0);
    end
    $display("copy: latency=%0d checks=%0d failures=%0d", n, checks, failures);
  endtask

  task automatic test_fill_wrap();
    int n, we0;
    preload(16'hFFFE, 24'h0); preload(16'hFFFF, 24'h0);
    preload(16'h0000, 24'h0); preload(16'h0001, 24'h111111);
    we0 = we_count;
    do_start(1'b1, 16'h0, 16'hFFFE, 16'd3, 24'h5A5A5A);
    wait_done(n);
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL fill_latency: DONE after %0d cycles required 3", n);
    end
    tick();
    checks++;
    if (mem[16'hFFFE] !== 24'h5A5A5A || mem[16'hFFFF] !== 24'h5A5A5A || mem[16'h0000] !== 24'h5A5A5A) begin
      failures++;
      $display("FAIL fill_data: FFFE=%h FFFF=%h 0000=%h required 5a5a5a",
               mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000]);
    end
    checks++;
    if (mem[16'h0001] !== 24'h111111 || we_count - we0 != 3) begin
      failures++;
      $display("FAIL fill_bounds: mem[1]=%h writes=%0d required 111111 3",
               mem[16'h0001], we_count - we0);
    end
    $display("fill_wrap: latency=%0d checks=%0d failures=%0d", n, checks, failures);
  endtask

  task automatic test_len_zero();
    int n, we0, oe0, done0, busy0;
    we0 = we_count; oe0 = oe_count; done0 = done_count; busy0 = busy_count;
    do_start(1'b0, 16'h0010, 16'h0100, 16'd0, 24'h0);
    wait_done(n);
    checks++;
    if (n != 0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL len0_done: DONE after %0d cycles BUSY=%b required 0 1", n, BUSY);
    end
    repeat (3) tick();
    checks++;
    if (we_count != we0 || oe_count != oe0) begin
      failures++;
      $display("FAIL len0_bus: writes=%0d reads=%0d required 0 0",
               we_count - we0, oe_count - oe0);
    end
    checks++;
    if (done_count - done0 != 1 || busy_count - busy0 != 1) begin
      failures++;
      $display("FAIL len0_pulses: dones=%0d busy_cycles=%0d required 1 1",
               done_count - done0, busy_count - busy0);
    end
    $display("len_zero: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_back_to_back();
    int n, we0, oe0, done0;
    preload(16'h0208, 24'h0);
    we0 = we_count; oe0 = oe_count; done0 = done_count;
    do_start(1'b1, 16'h0, 16'h0200, 16'd8, 24'h123456);
    tick(); tick();
    // A copy command arriving mid-fill must be dropped.
    MODE = 1'b0; SRC = 16'h0010; DST = 16'h0300; LEN = 16'd2; START = 1'b1;
    tick();
    START = 1'b0;
    wait_done(n);
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL b2b_latency: DONE %0d cycles after ignored START required 5", n);
    end
    repeat (5) tick();
    checks++;
    if (we_count - we0 != 8 || oe_count != oe0 || done_count - done0 != 1) begin
      failures++;
      $display("FAIL b2b_counts: writes=%0d reads=%0d dones=%0d required 8 0 1",
               we_count - we0, oe_count - oe0, done_count - done0);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[16'h0200 + 16'(i)] !== 24'h123456) begin
        failures++;
        $display("FAIL b2b_data[%0d]: got %h required 123456", i, mem[16'h0200 + 16'(i)]);
      end
    end
    checks++;
    if (mem[16'h0208] !== 24'h0) begin
      failures++;
      $display("FAIL b2b_overrun: mem[0208]=%h required 000000", mem[16'h0208]);
    end
    $display("back_to_back: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_abort();
    int we0, done0;
    for (int i = 0; i < 4; i++) preload(16'h0400 + 16'(i), 24'h0);
    we0 = we_count; done0 = done_count;
    do_start(1'b0, 16'h0010, 16'h0400, 16'd4, 24'h0);
    // Cycles: RD1, CAP1, WR1, RD2, CAP2 -- reset during CAP2.
    repeat (4) tick();
    RST_N = 1'b0;
    tick();
    checks++;
    if (RAM_WE !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs: WE=%b BUSY=%b DONE=%b required 0 0 0", RAM_WE, BUSY, DONE);
    end
    RST_N = 1'b1;
    repeat (15) tick();
    checks++;
    if (done_count != done0 || we_count - we0 != 1) begin
      failures++;
      $display("FAIL abort_counts: dones=%0d writes=%0d required 0 1",
               done_count - done0, we_count - we0);
    end
    checks++;
    if (mem[16'h0400] !== 24'hA00001 || mem[16'h0401] !== 24'h0 ||
        mem[16'h0402] !== 24'h0 || mem[16'h0403] !== 24'h0) begin
      failures++;
      $display("FAIL abort_data: %h %h %h %h required a00001 000000 000000 000000",
               mem[16'h0400], mem[16'h0401], mem[16'h0402], mem[16'h0403]);
    end
    $display("abort: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_overlap();
    int n;
    for (int i = 0; i < 4; i++) preload(16'(i), 24'(i + 1));
    do_start(1'b0, 16'h0000, 16'h0001, 16'd3, 24'h0);
    wait_done(n);
    checks++;
    if (n != 9) begin
      failures++;
      $display("FAIL overlap_latency: DONE after %0d cycles required 9", n);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'(i)] !== 24'd1) begin
        failures++;
        $display("FAIL overlap_data[%0d]: got %h required 000001", i, mem[16'(i)]);
      end
    end
    $display("overlap: checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill_wrap();
    test_len_zero();
    test_back_to_back();
    test_abort();
    test_overlap();
    checks++;
    if (both_count != 0) begin
      failures++;
      $display("FAIL we_oe_exclusive: %0d cycles with both high required 0", both_count);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_block_mover.md
RAM_BLOCK_MOVER -- requirements
Module: ram_block_mover

Interface
REQ-001 Parameter AW, default 16, RAM address width in bits.
REQ-002 Parameter DW, default 24, RAM data width in bits.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, named CK and RST_N.
REQ-004 CK  input  1  clock; all state changes on its rising edge.
REQ-005 RST_N  input  1  synchronous active-low reset.
REQ-006 START  input  1  command strobe; sampled only in IDLE.
REQ-007 MODE  input  1  0 = copy, 1 = fill.
REQ-008 SRC  input  AW  copy source base address.
REQ-009 DST  input  AW  destination base address, for both copy and fill.
REQ-010 LEN  input  AW  word count; 0 = no-op.
REQ-011 PATTERN  input  DW  fill value.
REQ-012 BUSY  output  1  high from the cycle after START is accepted until DONE.
REQ-013 DONE  output  1  one-cycle pulse at completion.
REQ-014 RAM_A  output  AW  RAM address, registered.
REQ-015 RAM_WE  output  1  RAM write enable, registered.
REQ-016 RAM_OE  output  1  RAM output enable, registered.
REQ-017 RAM_D  output  DW  RAM write data, registered.
REQ-018 RAM_Q  input  DW  RAM read data; valid in the cycle after RAM_A is sampled with RAM_OE=1.

Function
REQ-019 FSM states SHALL be IDLE, RD, CAP, WR, FILL and FIN.
REQ-020 In IDLE with START=1, the block SHALL latch SRC, DST, LEN, MODE and PATTERN, and set BUSY.
- Next state is FIN if LEN=0.
- Otherwise next state is RD if MODE=0, or FILL if MODE=1.
REQ-021 RD SHALL drive RAM_A=src_ptr, RAM_OE=1 and RAM_WE=0 for one cycle, then go to CAP.
REQ-022 CAP SHALL keep RAM_OE=1, capture RAM_Q into an internal buffer at the cycle end, then go to WR.
REQ-023 WR SHALL drive RAM_A=dst_ptr, RAM_WE=1 and RAM_D=buffer for one cycle.
- Both pointers increment.
- Remaining count decrements.
- Next state is RD if remaining>0, else FIN.
REQ-024 FILL SHALL drive RAM_A=dst_ptr, RAM_WE=1 and RAM_D=PATTERN every cycle, with dst_ptr incrementing and remaining decrementing, until remaining=0, then go to FIN.
REQ-025 Throughput SHALL be 3 cycles/word for copy and 1 cycle/word for fill.
REQ-026 FIN SHALL pulse DONE for exactly one cycle, clear BUSY in the same cycle, and return to IDLE.
REQ-027 Pointers SHALL wrap modulo 2^AW, e.g. 0xFFFF+1 = 0x0000.
REQ-028 Copy SHALL proceed in ascending address order, each word read then written before the next read.
- Results for overlapping ranges are those of that sequential order.
REQ-029 START while BUSY=1 SHALL be ignored.
- Command inputs may change freely after acceptance.
REQ-030 RAM_WE and RAM_OE SHALL never both be 1 in the same cycle.
REQ-031 Outside RD, CAP, WR and FILL, RAM_WE=0 and RAM_OE=0.

Reset
REQ-032 With RST_N=0 at a rising edge, the block SHALL enter IDLE, including mid-operation.
- Outputs: BUSY=0, DONE=0, RAM_WE=0, RAM_OE=0, RAM_A=0, RAM_D=0.
- Internal pointers, count and buffer SHALL be cleared.
REQ-033 An aborted transfer SHALL NOT assert DONE.
- Words already written stay written.
- No further writes occur.

Structure
REQ-034 Shared package ram_block_mover_pkg SHALL hold the state enum and the AW/DW defaults.
REQ-035 Pointer increment-with-wrap and count logic SHALL be one sub-module, ram_addr_gen, instantiated once.

Verification
REQ-036 The bench SHALL pair the block with a behavioural RAM model that latches the address on CK and returns read data one cycle later.
REQ-037 Copy SRC=0x0010, DST=0x0100, LEN=4, preloaded 0xA00001..0xA00004 -> DST..DST+3 hold the same values; DONE occurs 12 cycles after BUSY rises.
REQ-038 Fill DST=0xFFFE, LEN=3, PATTERN=0x5A5A5A -> 0xFFFE, 0xFFFF and 0x0000 written with the pattern; DONE after 3 write cycles.
REQ-039 START with LEN=0 -> no RAM_WE/RAM_OE activity; DONE pulses once; BUSY high for exactly one cycle.
REQ-040 Second START two cycles into a LEN=8 fill -> ignored; exactly 8 writes; one DONE.
REQ-041 RST_N=0 during the 2nd word of a LEN=4 copy -> next cycle RAM_WE=0, BUSY=0, no DONE, word 1 written, words 3-4 unchanged.
REQ-042 Overlapping copy SRC=0x0000, DST=0x0001, LEN=3, memory[0..3]=1,2,3,4 -> memory[0..3]=1,1,1,1.
